// File: rtl/montprod_opmem.sv
// Operand/result word banks and run sequencer for montprod: host loads A/B/M,
// starts a run, montprod reads operands and writes R, host reads R back.
module montprod_opmem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    we,
  input  logic [ADDR_WIDTH+1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    start,
  input  logic [7:0]              length,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              mp_length,
  output logic                    mp_calculate,
  input  logic                    mp_ready,
  input  logic [ADDR_WIDTH-1:0]   opa_addr,
  input  logic [ADDR_WIDTH-1:0]   opb_addr,
  input  logic [ADDR_WIDTH-1:0]   opm_addr,
  output logic [DATA_WIDTH-1:0]   opa_data,
  output logic [DATA_WIDTH-1:0]   opb_data,
  output logic [DATA_WIDTH-1:0]   opm_data,
  input  logic [ADDR_WIDTH-1:0]   result_addr,
  input  logic [DATA_WIDTH-1:0]   result_data,
  input  logic                    result_we
);

  localparam int DEPTH = 4 << ADDR_WIDTH;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PULSE     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  logic [2:0]            state_q, state_d;
  logic [7:0]            mp_length_q, mp_length_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  host_wr;

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign mp_calculate = (state_q == ST_PULSE);
  assign mp_length    = mp_length_q;
  assign read_data    = read_data_q;

  assign host_wr = cs & we & ~busy;

  assign opa_data = mem_q[{2'b00, opa_addr}];
  assign opb_data = mem_q[{2'b01, opb_addr}];
  assign opm_data = mem_q[{2'b10, opm_addr}];

  always_comb begin
    state_d     = state_q;
    mp_length_d = mp_length_q;
    read_data_d = read_data_q;
    if (cs && !we) begin
      read_data_d = mem_q[addr];
    end
    case (state_q)
      ST_IDLE: begin
        // Without mp_ready the start is simply not taken; the host keeps retrying.
        if (start) begin
          if (length == 8'd0) begin
            state_d = ST_DONE;
          end else if (mp_ready) begin
            state_d     = ST_PULSE;
            mp_length_d = length;
          end
        end
      end
      ST_PULSE:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!mp_ready) state_d = ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (mp_ready)  state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mp_length_q <= 8'd0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mp_length_q <= mp_length_d;
      read_data_q <= read_data_d;
    end
  end

  // Banks survive reset; the result write is last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      mem_q[addr] <= write_data;
    end
    if (result_we) begin
      mem_q[{2'b11, result_addr}] <= result_data;
    end
  end

endmodule

// File: tb/tb_montprod_opmem.sv
// Scoreboarded bench for montprod_opmem with a behavioural montprod stand-in
// and a shadow memory model of the four banks.
module tb_montprod_opmem;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        start;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  mp_length;
  logic        mp_calculate;
  logic        mp_ready;
  logic [7:0]  opa_addr;
  logic [7:0]  opb_addr;
  logic [7:0]  opm_addr;
  logic [31:0] opa_data;
  logic [31:0] opb_data;
  logic [31:0] opm_data;
  logic [7:0]  result_addr;
  logic [31:0] result_data;
  logic        result_we;

  int vectors     = 0;
  int miscompares = 0;
  int calc_cnt    = 0;
  int done_cnt    = 0;
  int stub_delay  = 2;

  logic [31:0] shadow [0:1023];
  logic [31:0] exp_q [$];
  logic        rd_req;

  always #5 clk = ~clk;

  montprod_opmem dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .we           (we),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .start        (start),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .mp_length    (mp_length),
    .mp_calculate (mp_calculate),
    .mp_ready     (mp_ready),
    .opa_addr     (opa_addr),
    .opb_addr     (opb_addr),
    .opm_addr     (opm_addr),
    .opa_data     (opa_data),
    .opb_data     (opb_data),
    .opm_data     (opm_data),
    .result_addr  (result_addr),
    .result_data  (result_data),
    .result_we    (result_we)
  );

  // Reference: (a*b mod m) halved modulo m 32 times, i.e. a*b*2^-32 mod m.
  function automatic logic [31:0] mont_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] m);
    logic [63:0] r;
    r = (64'(a) * 64'(b)) % 64'(m);
    for (int k = 0; k < 32; k++) begin
      r = r[0] ? ((r + 64'(m)) >> 1) : (r >> 1);
    end
    return r[31:0];
  endfunction

  // Bit-serial Montgomery product used by the montprod stand-in.
  function automatic logic [31:0] mont_stub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] m);
    logic [33:0] t;
    t = '0;
    for (int k = 0; k < 32; k++) begin
      if (a[k]) t = t + 34'(b);
      if (t[0]) t = t + 34'(m);
      t = t >> 1;
    end
    if (t >= 34'(m)) t = t - 34'(m);
    return t[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [9:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    cs = c;
    we = w;
    addr = a;
    write_data = d;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    shadow[a] = d;
  endtask

  task automatic host_read(input logic [9:0] a);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    exp_q.push_back(shadow[a]);
  endtask

  task automatic bus_idle();
    applyStimulus(1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic start_run(input int len);
    @(negedge clk);
    cs = 1'b0;
    we = 1'b0;
    length = 8'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("done_seen", 32'(done_cnt > d0), 32'h1);
  endtask

  // Expected R words once a run over len words has finished.
  task automatic model_results(input int len);
    for (int k = 0; k < len; k++) begin
      shadow[768 + k] = mont_ref(shadow[k], shadow[256 + k], shadow[512 + k]);
    end
  endtask

  // Scoreboard monitor: a read strobe at an edge is due on read_data right after it.
  always @(posedge clk) begin
    rd_req = cs && !we && !reset;
    #1;
    if (rd_req) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_read", read_data, 32'hxxxxxxxx);
      end else begin
        checkOutput("host_read", read_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mp_calculate) calc_cnt++;
    if (done) done_cnt++;
  end

  // montprod stand-in: drop ready, read operands word by word, write results, raise ready.
  initial begin : montprod_stub
    int n;
    logic [31:0] a, b, m;
    mp_ready = 1'b1;
    result_we = 1'b0;
    result_addr = '0;
    result_data = '0;
    opa_addr = '0;
    opb_addr = '0;
    opm_addr = '0;
    forever begin
      @(negedge clk);
      if (mp_calculate) begin
        n = int'(mp_length);
        mp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #1;
          result_we = 1'b0;
          opa_addr = i[7:0];
          opb_addr = i[7:0];
          opm_addr = i[7:0];
          #1;
          a = opa_data;
          b = opb_data;
          m = opm_data;
          result_addr = i[7:0];
          result_data = mont_stub(a, b, m);
          result_we = 1'b1;
        end
        @(posedge clk);
        #1;
        result_we = 1'b0;
        repeat (stub_delay) @(posedge clk);
        #1;
        mp_ready = 1'b1;
      end
    end
  end

  initial begin : main
    int c0, d0, len;
    logic [31:0] m, a, b;
    logic [9:0]  ra;

    reset = 1'b1;
    cs = 1'b0;
    we = 1'b0;
    addr = '0;
    write_data = '0;
    start = 1'b0;
    length = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_calc", 32'(mp_calculate), 32'h0);
    checkOutput("reset_mp_length", 32'(mp_length), 32'h0);
    checkOutput("reset_read_data", read_data, 32'h0);
    reset = 1'b0;

    // Single-word product 9*7*2^-32 mod 19 is 1.
    host_write(10'h000, 32'd9);
    host_write(10'h100, 32'd7);
    host_write(10'h200, 32'h13);
    bus_idle();
    c0 = calc_cnt;
    d0 = done_cnt;
    start_run(1);
    wait_done(d0, 200);
    model_results(1);
    checkOutput("t1_calc_count", 32'(calc_cnt - c0), 32'h1);
    checkOutput("t1_mp_length", 32'(mp_length), 32'h1);
    applyStimulus(1'b1, 1'b0, 10'h300, 32'h0);
    exp_q.push_back(32'h00000001);
    bus_idle();

    host_write(10'h005, 32'hDEADBEEF);
    host_read(10'h005);
    bus_idle();

    // Start held through a long run while the host tries to overwrite B[0].
    stub_delay = 15;
    c0 = calc_cnt;
    d0 = done_cnt;
    @(negedge clk);
    length = 8'd1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t3_busy", 32'(busy), 32'h1);
    cs = 1'b1;
    we = 1'b1;
    addr = 10'h100;
    write_data = 32'h1234;
    @(negedge clk);
    cs = 1'b0;
    we = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_done(d0, 200);
    model_results(1);
    repeat (5) @(negedge clk);
    checkOutput("t4_calc_count", 32'(calc_cnt - c0), 32'h1);
    checkOutput("t4_done_count", 32'(done_cnt - d0), 32'h1);
    host_read(10'h100);
    host_read(10'h300);
    bus_idle();

    // Zero length completes without a calculate pulse.
    stub_delay = 2;
    c0 = calc_cnt;
    d0 = done_cnt;
    start_run(0);
    wait_done(d0, 3);
    repeat (3) @(negedge clk);
    checkOutput("t5_calc_count", 32'(calc_cnt - c0), 32'h0);
    checkOutput("t5_done_count", 32'(done_cnt - d0), 32'h1);

    // Reset while waiting for montprod to finish.
    stub_delay = 20;
    c0 = calc_cnt;
    d0 = done_cnt;
    start_run(1);
    for (int k = 0; k < 20 && calc_cnt == c0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("t6_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_busy", 32'(busy), 32'h0);
    checkOutput("t6_done", 32'(done), 32'h0);
    checkOutput("t6_calc", 32'(mp_calculate), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 60 && !mp_ready; k++) @(negedge clk);
    checkOutput("t6_ready_back", 32'(mp_ready), 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("t6_no_done", 32'(done_cnt - d0), 32'h0);
    model_results(1);
    host_read(10'h000);
    host_read(10'h100);
    host_read(10'h200);
    host_read(10'h300);
    bus_idle();

    // Randomized multi-word runs plus scattered operand reads.
    stub_delay = 2;
    for (int it = 0; it < 20; it++) begin
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        m = $urandom | 32'h1;
        if (m < 32'd3) m = 32'd3;
        a = $urandom % m;
        b = $urandom % m;
        host_write(10'(k), a);
        host_write(10'(256 + k), b);
        host_write(10'(512 + k), m);
      end
      c0 = calc_cnt;
      d0 = done_cnt;
      start_run(len);
      wait_done(d0, 300);
      model_results(len);
      checkOutput("rnd_mp_length", 32'(mp_length), 32'(len));
      checkOutput("rnd_calc_count", 32'(calc_cnt - c0), 32'h1);
      for (int k = 0; k < len; k++) host_read(10'(768 + k));
      ra = 10'($urandom_range(0, 5) + 256 * $urandom_range(0, 2));
      host_read(ra);
      bus_idle();
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
